// File: rtl/cmesh_router.sv
// Wormhole XY router for concentrated 2D meshes, with a small per-input flit FIFO.
// Misaddressed packets are drained inside the router and counted.

// Generic synchronous FIFO with a combinational head read.
// Latency: a flit written at edge N is visible on rd_dat after edge N.
// Backpressure: full is raised at DEPTH entries; the caller gates wr_vld and rd_rdy.
module cmesh_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             full,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             rd_vld
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = (wr_ptr != rd_ptr);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_rdy) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

// Wormhole XY mesh router: locals, N, E, S, W with round-robin output locking.
// Latency: one cycle from input accept to output valid when the output is free.
// Backpressure: in_tready_o is !full; output data holds while out_tready_i is low.
module cmesh_router #(
  parameter  int DATA_WIDTH    = 40,
  parameter  int NUM_LOCAL     = 1,
  parameter  int MAX_ROUTERS_X = 3,
  parameter  int MAX_ROUTERS_Y = 3,
  parameter  int ROUTER_X      = 0,
  parameter  int ROUTER_Y      = 0,
  parameter  int FIFO_DEPTH    = 4,
  localparam int XW            = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
  localparam int YW            = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1,
  localparam int LW            = (NUM_LOCAL > 1) ? $clog2(NUM_LOCAL) : 1,
  localparam int DEST_WIDTH    = YW + XW + LW,
  localparam int P             = NUM_LOCAL + 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [P-1:0]            in_tvalid_i,
  output logic [P-1:0]            in_tready_o,
  input  logic [P*DATA_WIDTH-1:0] in_tdata_i,
  input  logic [P*DEST_WIDTH-1:0] in_tdest_i,
  input  logic [P-1:0]            in_tlast_i,
  output logic [P-1:0]            out_tvalid_o,
  input  logic [P-1:0]            out_tready_i,
  output logic [P*DATA_WIDTH-1:0] out_tdata_o,
  output logic [P*DEST_WIDTH-1:0] out_tdest_o,
  output logic [P-1:0]            out_tlast_o,
  output logic [15:0]             drop_cnt_o
);
  localparam int PW = $clog2(P);
  localparam int FW = DATA_WIDTH + DEST_WIDTH + 1;
  localparam logic [PW-1:0] NORTH = PW'(NUM_LOCAL);
  localparam logic [PW-1:0] EAST  = PW'(NUM_LOCAL + 1);
  localparam logic [PW-1:0] SOUTH = PW'(NUM_LOCAL + 2);
  localparam logic [PW-1:0] WEST  = PW'(NUM_LOCAL + 3);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  last;
  } flit_t;

  typedef enum logic [1:0] {IDLE, REQ, FWD, DROP} state_t;

  state_t                state_q [P];
  state_t                state_d [P];
  flit_t                 head    [P];
  logic [DEST_WIDTH-1:0] dest_q  [P];
  logic [PW-1:0]         route   [P];
  logic [PW-1:0]         owner_q [P];
  logic [PW-1:0]         owner   [P];
  logic [PW-1:0]         gnt_idx [P];
  logic [PW-1:0]         rr_ptr  [P];
  logic [P-1:0]          head_q, head_vld, full, push, pop, route_ok, req, gnt_in, drop_done;
  logic [P-1:0]          lock_q, gnt_vld, out_vld, hs;
  logic [16:0]           drop_sum;
  int                    idx;

  // Returns {ok, port}; out-of-grid targets and U-turns are not ok.
  function automatic logic [PW:0] xy_route(input logic [DEST_WIDTH-1:0] d, input int self);
    logic [31:0]   ux, uy, ul;
    logic [PW-1:0] port;
    logic          ok;
    ul = 32'(d[LW-1:0]);
    ux = 32'(d[LW +: XW]);
    uy = 32'(d[LW+XW +: YW]);
    ok = (ux < MAX_ROUTERS_X) && (uy < MAX_ROUTERS_Y);
    if (ux > ROUTER_X)       port = EAST;
    else if (ux != ROUTER_X) port = WEST;
    else if (uy > ROUTER_Y)  port = SOUTH;
    else if (uy != ROUTER_Y) port = NORTH;
    else begin
      port = PW'(ul);
      ok   = ok && (ul < NUM_LOCAL);
    end
    ok = ok && (32'(port) != self);
    return {ok, port};
  endfunction

  assign in_tready_o  = ~full & {P{~rst_i}};
  assign push         = in_tvalid_i & in_tready_o;
  assign out_tvalid_o = out_vld;

  for (genvar g = 0; g < P; g++) begin : g_in
    logic [FW-1:0] rd;
    cmesh_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_vld (push[g]),
      .wr_dat ({in_tdata_i[g*DATA_WIDTH +: DATA_WIDTH], in_tdest_i[g*DEST_WIDTH +: DEST_WIDTH], in_tlast_i[g]}),
      .full   (full[g]),
      .rd_rdy (pop[g]),
      .rd_dat (rd),
      .rd_vld (head_vld[g])
    );
    assign head[g] = rd;
  end

  always_comb begin
    for (int i = 0; i < P; i++) begin
      {route_ok[i], route[i]} = xy_route(head[i].dest, i);
      req[i] = head_vld[i] && head_q[i] && route_ok[i] && (state_q[i] == IDLE || state_q[i] == REQ);
    end
  end

  // Unlocked outputs scan requesters starting from their round-robin pointer.
  always_comb begin
    idx = 0;
    for (int o = 0; o < P; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      if (!lock_q[o]) begin
        for (int k = 0; k < P; k++) begin
          idx = int'(rr_ptr[o]) + k;
          if (idx >= P) idx = idx - P;
          if (!gnt_vld[o] && req[idx] && route[idx] == PW'(o)) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = PW'(idx);
          end
        end
      end
      owner[o]   = lock_q[o] ? owner_q[o] : gnt_idx[o];
      out_vld[o] = (lock_q[o] | gnt_vld[o]) & head_vld[owner[o]];
      hs[o]      = out_vld[o] & out_tready_i[o];
    end
  end

  always_comb begin
    pop         = '0;
    gnt_in      = '0;
    drop_done   = '0;
    out_tdata_o = '0;
    out_tdest_o = '0;
    out_tlast_o = '0;
    for (int i = 0; i < P; i++) begin
      if (state_q[i] == DROP && head_vld[i]) pop[i] = 1'b1;
    end
    for (int o = 0; o < P; o++) begin
      if (gnt_vld[o]) gnt_in[gnt_idx[o]] = 1'b1;
      if (hs[o]) pop[owner[o]] = 1'b1;
      out_tdata_o[o*DATA_WIDTH +: DATA_WIDTH] = head[owner[o]].data;
      out_tdest_o[o*DEST_WIDTH +: DEST_WIDTH] = (state_q[owner[o]] == FWD) ? dest_q[owner[o]]
                                                                            : head[owner[o]].dest;
      out_tlast_o[o] = head[owner[o]].last;
    end
    for (int i = 0; i < P; i++) begin
      drop_done[i] = (state_q[i] == DROP) && pop[i] && head[i].last;
    end
  end

  always_comb begin
    for (int i = 0; i < P; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE, REQ: begin
          if (head_vld[i] && head_q[i]) begin
            if (!route_ok[i])    state_d[i] = DROP;
            else if (gnt_in[i])  state_d[i] = (pop[i] && head[i].last) ? IDLE : FWD;
            else                 state_d[i] = REQ;
          end
        end
        FWD, DROP: begin
          if (pop[i] && head[i].last) state_d[i] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '1;
      for (int i = 0; i < P; i++) begin
        state_q[i] <= IDLE;
        dest_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < P; i++) begin
        state_q[i] <= state_d[i];
        if (pop[i]) head_q[i] <= head[i].last;
        if (state_q[i] == IDLE || state_q[i] == REQ) dest_q[i] <= head[i].dest;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q <= '0;
      for (int o = 0; o < P; o++) begin
        owner_q[o] <= '0;
        rr_ptr[o]  <= '0;
      end
    end else begin
      for (int o = 0; o < P; o++) begin
        if (hs[o] && out_tlast_o[o]) begin
          lock_q[o] <= 1'b0;
          rr_ptr[o] <= (owner[o] == PW'(P - 1)) ? '0 : owner[o] + 1'b1;
        end else if (gnt_vld[o]) begin
          lock_q[o]  <= 1'b1;
          owner_q[o] <= gnt_idx[o];
        end
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_o};
    for (int i = 0; i < P; i++) begin
      if (drop_done[i]) drop_sum = drop_sum + 17'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_cnt_o <= '0;
    else       drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
endmodule
